sram_responder: RTL and testbench

- Clocked, synthesizable responder for the external 16-bit asynchronous SRAM bus that the CPU bus interface drives (19-bit address, 16-bit bidirectional data, active-low chip enable, output enable, write enable and byte enables).
- Replaces the board SRAM in simulation and in FPGA builds without external memory, so the system top can run out of on-chip RAM.
- Runs on the bus clock, samples the bus controls every cycle, commits writes on the trailing edge of the write strobe, and drives read data after a programmable latency.

---
 rtl/sram_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_sram_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for the external 16-bit asynchronous SRAM.
// Clears its on-chip storage after reset, then answers the CPU bus interface:
// writes commit on the trailing edge of the write strobe, reads drive the data
// bus once addr/ub/lb have been stable for READ_LAT cycles.
//
// Ports:
//   clk        bus clock, all inputs sampled on the rising edge
//   rst        asynchronous active-high reset
//   sram_addr  word address (bits above DEPTH_W-1 alias)
//   sram_data  bidirectional data bus, driven only during a valid read
//   sram_ce_n  chip enable, active low
//   sram_oe_n  output enable, active low
//   sram_we_n  write enable, active low
//   sram_ub    upper byte enable (bits 15:8), active low
//   sram_lb    lower byte enable (bits 7:0), active low
//   ready      high once the post-reset clear has completed
//   collision  sticky: we_n and oe_n sampled low together with ce_n low
//   wr_count   number of committed writes, wraps at 16'hFFFF
module sram_responder #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DEPTH_W  = 12,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_data,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  input  logic              sram_we_n,
  input  logic              sram_ub,
  input  logic              sram_lb,
  output logic              ready,
  output logic              collision,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT     = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  // Storage split into byte lanes so each lane has its own write enable.
  logic [7:0] r_mem_hi [DEPTH];
  logic [7:0] r_mem_lo [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DEPTH_W-1:0] r_init_addr;

  // Read stability tracking
  logic [ADDR_W-1:0]  r_prev_addr;
  logic               r_prev_ub;
  logic               r_prev_lb;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_same;

  // Pending write captured while the strobe is low
  logic [DEPTH_W-1:0] r_wr_idx;
  logic [15:0]        r_wr_data;
  logic               r_wr_ub;
  logic               r_wr_lb;
  logic               w_capture;
  logic               w_commit;

  // Read data path and registered lane drive enables
  logic [15:0]        r_rd_data;
  logic               r_drive_hi;
  logic               r_drive_lo;
  logic               w_drive_nxt;

  // Memory write port
  logic [DEPTH_W-1:0] w_mem_idx;
  logic [15:0]        w_mem_din;
  logic               w_mem_we_hi;
  logic               w_mem_we_lo;

  logic               w_req_wr;
  logic               w_req_rd;
  logic               w_col;
  logic [DEPTH_W-1:0] w_idx;

  assign w_req_wr = ~sram_ce_n & ~sram_we_n;
  assign w_req_rd = ~sram_ce_n & ~sram_oe_n & sram_we_n;
  assign w_col    = ~sram_ce_n & ~sram_we_n & ~sram_oe_n;
  assign w_idx    = sram_addr[DEPTH_W-1:0];
  assign w_same   = (sram_addr == r_prev_addr) && (sram_ub == r_prev_ub) &&
                    (sram_lb == r_prev_lb);

  // The trailing edge of the write strobe commits the last captured beat.
  assign w_commit = (r_state == S_WRITE) && !w_req_wr;

  // Bus drive: each lane only when its registered enable is set.
  assign sram_data[15:8] = r_drive_hi ? r_rd_data[15:8] : 8'hzz;
  assign sram_data[7:0]  = r_drive_lo ? r_rd_data[7:0]  : 8'hzz;

  // State register and all sequential control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_init_addr <= '0;
      ready       <= 1'b0;
      collision   <= 1'b0;
      wr_count    <= '0;
      r_cnt       <= '0;
      r_prev_addr <= '0;
      r_prev_ub   <= 1'b1;
      r_prev_lb   <= 1'b1;
      r_wr_idx    <= '0;
      r_wr_data   <= '0;
      r_wr_ub     <= 1'b1;
      r_wr_lb     <= 1'b1;
      r_drive_hi  <= 1'b0;
      r_drive_lo  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      ready       <= (w_state_nxt != S_INIT);
      r_prev_addr <= sram_addr;
      r_prev_ub   <= sram_ub;
      r_prev_lb   <= sram_lb;
      r_drive_hi  <= w_drive_nxt & ~sram_ub;
      r_drive_lo  <= w_drive_nxt & ~sram_lb;

      if (r_state == S_INIT) begin
        r_init_addr <= r_init_addr + DEPTH_W'(1);
      end

      if ((r_state != S_INIT) && w_col) begin
        collision <= 1'b1;
      end

      if (w_capture) begin
        r_wr_idx  <= w_idx;
        r_wr_data <= sram_data;
        r_wr_ub   <= sram_ub;
        r_wr_lb   <= sram_lb;
      end

      if (w_commit) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Next-state, capture, latency counter and drive decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_drive_nxt = 1'b0;

    case (r_state)
      S_INIT: begin
        if (&r_init_addr) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        if (w_req_wr) begin
          w_state_nxt = S_WRITE;
          w_capture   = 1'b1;
        end else if (w_req_rd) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end
      end

      S_WRITE: begin
        if (w_req_wr) begin
          w_capture = 1'b1;
        end else if (w_req_rd) begin
          // Read starts at count 0, so it cannot see data before the commit lands.
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_READ: begin
        if (w_req_wr) begin
          w_state_nxt = S_WRITE;
          w_capture   = 1'b1;
        end else if (w_req_rd) begin
          if (w_same) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
          end else begin
            w_cnt_nxt = '0;
          end
          w_drive_nxt = (w_cnt_nxt >= LAT);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Memory write port: clear sweep during INIT, otherwise committed writes.
  always_comb begin
    w_mem_idx   = r_wr_idx;
    w_mem_din   = r_wr_data;
    w_mem_we_hi = 1'b0;
    w_mem_we_lo = 1'b0;
    if (r_state == S_INIT) begin
      w_mem_idx   = r_init_addr;
      w_mem_din   = 16'h0000;
      w_mem_we_hi = 1'b1;
      w_mem_we_lo = 1'b1;
    end else if (w_commit) begin
      w_mem_we_hi = ~r_wr_ub;
      w_mem_we_lo = ~r_wr_lb;
    end
  end

  // Storage array with registered read
  always_ff @(posedge clk) begin
    if (w_mem_we_hi) begin
      r_mem_hi[w_mem_idx] <= w_mem_din[15:8];
    end
    if (w_mem_we_lo) begin
      r_mem_lo[w_mem_idx] <= w_mem_din[7:0];
    end
    if (w_drive_nxt) begin
      r_rd_data <= {r_mem_hi[w_idx], r_mem_lo[w_idx]};
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized self-checking bench for sram_responder with a
// word-array reference model of the SRAM contents and write counter.
module tb_sram_responder;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DEPTH_W  = 12;
  localparam int unsigned READ_LAT = 1;
  localparam int unsigned DEPTH    = 1 << DEPTH_W;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  wire  [15:0]       sram_data;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              ub;
  logic              lb;
  logic              ready;
  logic              collision;
  logic [15:0]       wr_count;

  logic              tb_oe;
  logic [15:0]       tb_wdata;

  int n_tests;
  int n_fail;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_wr_count;

  assign sram_data = tb_oe ? tb_wdata : 16'hzzzz;

  sram_responder #(
    .ADDR_W  (ADDR_W),
    .DEPTH_W (DEPTH_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sram_addr(addr),
    .sram_data(sram_data),
    .sram_ce_n(ce_n),
    .sram_oe_n(oe_n),
    .sram_we_n(we_n),
    .sram_ub  (ub),
    .sram_lb  (lb),
    .ready    (ready),
    .collision(collision),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    ub    = 1'b1;
    lb    = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 16'h0000;
    model_wr_count = 16'h0000;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                             input logic u, input logic l);
    logic [DEPTH_W-1:0] idx;
    idx = a[DEPTH_W-1:0];
    if (!u) model_mem[idx][15:8] = d[15:8];
    if (!l) model_mem[idx][7:0]  = d[7:0];
    model_wr_count = model_wr_count + 16'd1;
  endtask

  // Strobe held low for 'hold' sampled cycles, then released (commit edge).
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                          input logic u, input logic l, input int hold);
    addr = a; tb_wdata = d; tb_oe = 1'b1; ub = u; lb = l;
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    repeat (hold) tick();
    bus_idle();
    tick();
  endtask

  // early: bus right after READ is entered; val: after READ_LAT stable edges;
  // post: after the exit edge.
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic u, input logic l,
                         output logic [15:0] early, output logic [15:0] val,
                         output logic [15:0] post);
    addr = a; ub = u; lb = l; tb_oe = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick();
    early = sram_data;
    repeat (READ_LAT) tick();
    val = sram_data;
    bus_idle();
    tick();
    post = sram_data;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 5000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] e, v, p;
    int cyc;
    rst = 1'b1;
    bus_idle();
    addr = '0; tb_wdata = '0;
    model_clear();
    repeat (3) tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b expected 0", collision); end
    n_tests++; if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
    rst = 1'b0;
    wait_ready(cyc);
    n_tests++; if (cyc != 4096) begin n_fail++; $display("FAIL init_cycles: got %0d expected 4096", cyc); end
    do_read(19'h00ABC, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL init_read: got %h expected 0000", v); end
  endtask

  task automatic test_write_read();
    logic [15:0] e, v, p;
    do_write(19'h00010, 16'hBEEF, 1'b0, 1'b0, 2);
    model_write(19'h00010, 16'hBEEF, 1'b0, 1'b0);
    n_tests++; if (wr_count !== model_wr_count) begin n_fail++; $display("FAIL wr_count_1: got %h expected %h", wr_count, model_wr_count); end
    do_read(19'h00010, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== 16'hBEEF) begin n_fail++; $display("FAIL write_read: got %h expected BEEF", v); end
    n_tests++; if (e !== 16'hzzzz && e !== 16'h0000) begin n_fail++; $display("FAIL read_latency: got %h expected Z", e); end
    n_tests++; if (p !== 16'hzzzz && p !== 16'h0000) begin n_fail++; $display("FAIL read_release: got %h expected Z", p); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] e, v, p;
    do_write(19'h00005, 16'hBEEF, 1'b0, 1'b0, 1);
    model_write(19'h00005, 16'hBEEF, 1'b0, 1'b0);
    do_write(19'h00005, 16'h1234, 1'b1, 1'b0, 1);
    model_write(19'h00005, 16'h1234, 1'b1, 1'b0);
    do_read(19'h00005, 1'b0, 1'b1, e, v, p);
    n_tests++; if (v[15:8] !== 8'hBE) begin n_fail++; $display("FAIL lane_upper: got %h expected BE", v[15:8]); end
    n_tests++; if (v[7:0] !== 8'hzz && v[7:0] !== 8'h00) begin n_fail++; $display("FAIL lane_lower_z: got %h expected Z", v[7:0]); end
    do_read(19'h00005, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== model_mem[5]) begin n_fail++; $display("FAIL lane_merge: got %h expected %h", v, model_mem[5]); end
    n_tests++; if (wr_count !== model_wr_count) begin n_fail++; $display("FAIL wr_count_3: got %h expected %h", wr_count, model_wr_count); end
  endtask

  task automatic test_aliasing();
    logic [15:0] e, v, p;
    do_write(19'h01010, 16'h5555, 1'b0, 1'b0, 1);
    model_write(19'h01010, 16'h5555, 1'b0, 1'b0);
    do_read(19'h00010, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== 16'h5555) begin n_fail++; $display("FAIL aliasing: got %h expected 5555", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int k = 0; k < 3; k++) begin
      logic [ADDR_W-1:0] a;
      logic [15:0] d;
      a = ADDR_W'($urandom);
      d = 16'($urandom) | 16'h0101;
      addr = a; tb_wdata = d; tb_oe = 1'b1; ub = 1'b0; lb = 1'b0;
      ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
      tick();
      // Strobe release and read request on the same cycle
      tb_oe = 1'b0; we_n = 1'b1; oe_n = 1'b0;
      tick();
      model_write(a, d, 1'b0, 1'b0);
      repeat (READ_LAT) tick();
      v = sram_data;
      n_tests++; if (v !== model_mem[a[DEPTH_W-1:0]]) begin n_fail++; $display("FAIL back_to_back_%0d: got %h expected %h", k, v, model_mem[a[DEPTH_W-1:0]]); end
      bus_idle();
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] e, v, p, exp_w;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    logic u, l;
    for (int k = 0; k < 60; k++) begin
      // Small pool of low indices with random upper bits exercises aliasing.
      a = {7'($urandom), 9'd0, 3'($urandom_range(0, 7))};
      u = 1'($urandom);
      l = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        d = 16'($urandom);
        do_write(a, d, u, l, int'($urandom_range(1, 3)));
        model_write(a, d, u, l);
      end else begin
        do_read(a, u, l, e, v, p);
        exp_w = model_mem[a[DEPTH_W-1:0]];
        if (!u) begin
          n_tests++; if (v[15:8] !== exp_w[15:8]) begin n_fail++; $display("FAIL rand_read_hi_%0d: got %h expected %h", k, v[15:8], exp_w[15:8]); end
        end else begin
          n_tests++; if (v[15:8] !== 8'hzz && v[15:8] !== 8'h00) begin n_fail++; $display("FAIL rand_hi_z_%0d: got %h expected Z", k, v[15:8]); end
        end
        if (!l) begin
          n_tests++; if (v[7:0] !== exp_w[7:0]) begin n_fail++; $display("FAIL rand_read_lo_%0d: got %h expected %h", k, v[7:0], exp_w[7:0]); end
        end else begin
          n_tests++; if (v[7:0] !== 8'hzz && v[7:0] !== 8'h00) begin n_fail++; $display("FAIL rand_lo_z_%0d: got %h expected Z", k, v[7:0]); end
        end
      end
    end
    n_tests++; if (wr_count !== model_wr_count) begin n_fail++; $display("FAIL rand_wr_count: got %h expected %h", wr_count, model_wr_count); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL rand_no_collision: got %b expected 0", collision); end
  endtask

  task automatic test_collision();
    logic [15:0] e, v, p;
    do_write(19'h00020, 16'h9A6B, 1'b0, 1'b0, 1);
    model_write(19'h00020, 16'h9A6B, 1'b0, 1'b0);
    // Read until the block is driving, then drop we_n with oe_n still low.
    addr = 19'h00020; ub = 1'b0; lb = 1'b0; tb_oe = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick();
    repeat (READ_LAT) tick();
    v = sram_data;
    n_tests++; if (v !== 16'h9A6B) begin n_fail++; $display("FAIL pre_collision_read: got %h expected 9A6B", v); end
    we_n = 1'b0; tb_wdata = 16'hC3C3; tb_oe = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_set_%0d: got %b expected 1", k, collision); end
      tb_oe = 1'b0;
      #1;
      v = sram_data;
      n_tests++; if (v !== 16'hzzzz && v !== 16'h0000) begin n_fail++; $display("FAIL collision_bus_%0d: got %h expected Z", k, v); end
      tb_oe = 1'b1;
    end
    bus_idle();
    tick();
    model_write(19'h00020, 16'hC3C3, 1'b0, 1'b0);
    n_tests++; if (wr_count !== model_wr_count) begin n_fail++; $display("FAIL collision_commit_count: got %h expected %h", wr_count, model_wr_count); end
    do_read(19'h00020, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== 16'hC3C3) begin n_fail++; $display("FAIL collision_commit_data: got %h expected C3C3", v); end
    n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_sticky: got %b expected 1", collision); end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] e, v, p;
    int cyc;
    addr = 19'h00007; tb_wdata = 16'hAAAA; tb_oe = 1'b1; ub = 1'b0; lb = 1'b0;
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midwrite_ready: got %b expected 0", ready); end
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL midwrite_collision: got %b expected 0", collision); end
    n_tests++; if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL midwrite_wr_count: got %h expected 0000", wr_count); end
    tick();
    bus_idle();
    tick();
    model_clear();
    rst = 1'b0;
    wait_ready(cyc);
    n_tests++; if (cyc != 4096) begin n_fail++; $display("FAIL reinit_cycles: got %0d expected 4096", cyc); end
    n_tests++; if (wr_count !== model_wr_count) begin n_fail++; $display("FAIL reinit_wr_count: got %h expected %h", wr_count, model_wr_count); end
    do_read(19'h00007, 1'b0, 1'b0, e, v, p);
    n_tests++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reinit_read: got %h expected 0000", v); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_aliasing();
    test_back_to_back();
    test_random();
    test_collision();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
